uart_cmd_rx: RTL and testbench
==============================

// Module: uart_cmd_rx
// PURPOSE
//  UART receiver and command decoder upstream of the watch/stopwatch top. Deserialises 8N1
//  frames from the PC on rx and turns ASCII commands into stretched button-equivalent pulses.
//  The top ORs these pulses with btnL_clear/btnR_runstop/btnU_up/btnD_down ahead of its
//  debouncers. Raw byte and status strobes are also exported for a later TX echo stage.
// PARAMETERS
//  CLK_FREQ   100_000_000  system clock in Hz
//  BAUD       9600         line rate in bit/s
//  OVS        16           oversampling ticks per bit
//  PULSE_CYC  2_000_000    button pulse length in clocks (20 ms; must exceed debounce window)
// PORTS
//  clk            in   1  system clock; all logic on the rising edge
//  rst            in   1  reset, asynchronous, active-low
//  rx             in   1  UART serial input, idle high, asynchronous to clk
//  rx_data        out  8  last good byte received
//  rx_done        out  1  1-clk strobe: rx_data updated
//  frame_err      out  1  1-clk strobe: stop bit sampled 0
//  o_btn_clear    out  1  stretched pulse for 'C'/'c'
//  o_btn_runstop  out  1  stretched pulse for 'R'/'r'
//  o_btn_up       out  1  stretched pulse for 'U'/'u'
//  o_btn_down     out  1  stretched pulse for 'D'/'d'
// BEHAVIOUR
//  Reset (rst=0): every output 0, rx_data=8'h00, FSM=IDLE, all counters 0, sync flops=1.
//  Synchroniser: 2-flop on rx gives rx_s. Only rx_s is used.
//  Tick gen: DIV=CLK_FREQ/(BAUD*OVS)=651 (integer divide). Counter runs 0..DIV-1.
//   tick=1 for one clk at DIV-1. Tick gen free-runs and is never re-aligned.
//  FSM (advances only on tick). tcnt is a 4-bit tick counter; bcnt is a 3-bit bit counter.
//   IDLE : rx_s==0 -> START, tcnt=0.
//   START: tcnt==OVS/2-1 (7): rx_s==0 -> DATA, tcnt=0, bcnt=0.
//          Otherwise (glitch) -> IDLE, with no strobe.
//   DATA : tcnt==OVS-1: shift rx_s in LSB-first, tcnt=0.
//          bcnt==7 -> STOP, else bcnt+1.
//   STOP : tcnt==OVS-1: rx_s==1 -> rx_data<=shift, rx_done=1 for the next clk.
//          rx_s==0 -> frame_err=1 for the next clk, rx_data unchanged.
//          Either way -> IDLE. A new start is accepted on the following tick.
//  Decode: on rx_done, compare the byte with 'C','c','R','r','U','u','D','d'.
//   Match and stretcher idle: assert the matching o_btn_* on the next clk.
//    Hold it exactly PULSE_CYC clks via a down-counter (width $clog2(PULSE_CYC+1)).
//   Match while any o_btn_* is high: the command is dropped, with no queue and no restart.
//   Non-matching byte: rx_done still strobes, no o_btn_* activity.
//   At most one o_btn_* is high at any time (one-hot or zero).
//  Latency: rx_done is 1 clk after the STOP mid-bit tick. o_btn_* is 1 clk after rx_done.
//  Reset mid-frame or mid-pulse: immediate return to the reset state.
//   The partial byte is discarded and the pulse is cut.
//  Line held low (break): one frame_err, then a START->IDLE loop with no further strobes.
//   Normal reception resumes after rx returns high.
// STRUCTURE
//  Header uart_cmd_defs.vh: ASCII command constants, FSM state encodings
//   (IDLE=2'd0, START=1, DATA=2, STOP=3).
//  Sub-module baud_tick_gen (params CLK_FREQ, BAUD, OVS; ports clk, rst, tick).
//   It is reused by the future uart_tx.
//  RX FSM, decoder and pulse stretcher stay inline in uart_cmd_rx.
// TESTING (clk 10 ns; sims override PULSE_CYC=1000, bit time = 16*651 clks)
//  1. Send 0x52 'R' -> rx_data=8'h52, rx_done high 1 clk ~9.5 bit times after the start edge.
//     o_btn_runstop is high exactly 1000 clks; the other buttons stay 0.
//  2. Send 'c','U','d' with one idle bit between frames -> rx_data 8'h63, 8'h55, 8'h64 in order.
//     o_btn_clear, o_btn_up, o_btn_down fire in sequence, 1000 clks each, never overlapping.
//  3. With PULSE_CYC=200_000, send 'U' then 'D' back-to-back -> o_btn_up high 200_000 clks.
//     o_btn_down never rises; rx_done strobes twice.
//  4. Pull rx low for 3 ticks, then high -> no rx_done, no frame_err, FSM back in IDLE.
//     A following 'R' is received correctly.
//  5. Send 0x55 with the stop bit forced 0 -> frame_err 1 clk, rx_data keeps its previous value.
//     No o_btn_* rises.
//  6. Send 'x' (0x78) -> rx_done, rx_data=8'h78, no button.
//     Assert rst=0 mid-frame of 'R' -> all outputs 0 immediately; after release no rx_done
//     from the truncated frame.

Source files
------------

// File: rtl/uart_cmd_rx_pkg.sv
// Shared constants for the UART command receiver: FSM state codes, the
// ASCII command set and the byte-to-button decode helper.
package uart_cmd_rx_pkg;

    // Receiver FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // ASCII command characters (both cases accepted)
    localparam logic [7:0] ASC_CLEAR_UC   = 8'h43; // 'C'
    localparam logic [7:0] ASC_CLEAR_LC   = 8'h63; // 'c'
    localparam logic [7:0] ASC_RUNSTOP_UC = 8'h52; // 'R'
    localparam logic [7:0] ASC_RUNSTOP_LC = 8'h72; // 'r'
    localparam logic [7:0] ASC_UP_UC      = 8'h55; // 'U'
    localparam logic [7:0] ASC_UP_LC      = 8'h75; // 'u'
    localparam logic [7:0] ASC_DOWN_UC    = 8'h44; // 'D'
    localparam logic [7:0] ASC_DOWN_LC    = 8'h64; // 'd'

    // Button vector layout: {down, up, runstop, clear}
    localparam logic [3:0] BTN_NONE    = 4'b0000;
    localparam logic [3:0] BTN_CLEAR   = 4'b0001;
    localparam logic [3:0] BTN_RUNSTOP = 4'b0010;
    localparam logic [3:0] BTN_UP      = 4'b0100;
    localparam logic [3:0] BTN_DOWN    = 4'b1000;

    // Map a received byte onto a one-hot button vector (all zero if not a command)
    function automatic logic [3:0] cmd_decode(input logic [7:0] b);
        logic [3:0] r;
        r = BTN_NONE;
        case (b)
            ASC_CLEAR_UC,   ASC_CLEAR_LC:   r = BTN_CLEAR;
            ASC_RUNSTOP_UC, ASC_RUNSTOP_LC: r = BTN_RUNSTOP;
            ASC_UP_UC,      ASC_UP_LC:      r = BTN_UP;
            ASC_DOWN_UC,    ASC_DOWN_LC:    r = BTN_DOWN;
            default:                        r = BTN_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_cmd_rx_baud_tick_gen.sv
// Free-running oversampling tick generator. The tick is a registered one-clock
// pulse while the divider sits at its last count; it is never re-aligned to
// the line, so the receiver copes with up to one tick of sampling jitter.
module baud_tick_gen #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int OVS      = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = CLK_FREQ / (BAUD * OVS);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter 0..DIV-1; tick registered so it is high exactly while cnt_r==DIV-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            tick_r <= (cnt_r == CNT_PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver with ASCII command decode. Received command letters become
// fixed-length button pulses that the watch top ORs with its push buttons.
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int OVS       = 16,
    parameter int PULSE_CYC = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       o_btn_clear,
    output logic       o_btn_runstop,
    output logic       o_btn_up,
    output logic       o_btn_down
);

    localparam logic [3:0] T_MID = 4'(OVS / 2 - 1);
    localparam logic [3:0] T_END = 4'(OVS - 1);
    localparam int         PW    = $clog2(PULSE_CYC + 1);
    localparam logic [PW-1:0] P_LOAD = PW'(PULSE_CYC - 1);
    localparam logic [PW-1:0] P_ONE  = PW'(1);

    logic          tick_s;
    logic          rx_meta_r;
    logic          rx_sync_r;
    logic [1:0]    state_r;
    logic [3:0]    tcnt_r;
    logic [2:0]    bcnt_r;
    logic [7:0]    shift_r;
    logic          brk_r;
    logic [7:0]    rx_data_r;
    logic          rx_done_r;
    logic          frame_err_r;
    logic [3:0]    btn_r;
    logic [PW-1:0] pcnt_r;
    logic [3:0]    cmd_s;

    baud_tick_gen #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .OVS     (OVS)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick_s)
    );

    // Two-flop synchroniser for the asynchronous line; resets to the idle-high level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Frame FSM: start validation at mid-bit, LSB-first data, stop check with strobes.
    // brk_r blocks new starts after a framing error until the line is seen high,
    // so a held-low line (break) yields a single frame_err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            tcnt_r      <= 4'd0;
            bcnt_r      <= 3'd0;
            shift_r     <= 8'h00;
            brk_r       <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_done_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_done_r   <= 1'b0;
            frame_err_r <= 1'b0;
            if (tick_s) begin
                case (state_r)
                    ST_IDLE: begin
                        tcnt_r <= 4'd0;
                        if (rx_sync_r) begin
                            brk_r <= 1'b0;
                        end else if (!brk_r) begin
                            state_r <= ST_START;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_START: begin
                        if (tcnt_r == T_MID) begin
                            tcnt_r  <= 4'd0;
                            bcnt_r  <= 3'd0;
                            state_r <= rx_sync_r ? ST_IDLE : ST_DATA;
                        end else begin
                            tcnt_r <= tcnt_r + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        if (tcnt_r == T_END) begin
                            tcnt_r  <= 4'd0;
                            shift_r <= {rx_sync_r, shift_r[7:1]};
                            if (bcnt_r == 3'd7) begin
                                state_r <= ST_STOP;
                            end else begin
                                bcnt_r <= bcnt_r + 3'd1;
                            end
                        end else begin
                            tcnt_r <= tcnt_r + 4'd1;
                        end
                    end
                    ST_STOP: begin
                        if (tcnt_r == T_END) begin
                            tcnt_r  <= 4'd0;
                            state_r <= ST_IDLE;
                            if (rx_sync_r) begin
                                rx_data_r <= shift_r;
                                rx_done_r <= 1'b1;
                            end else begin
                                frame_err_r <= 1'b1;
                                brk_r       <= 1'b1;
                            end
                        end else begin
                            tcnt_r <= tcnt_r + 4'd1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        tcnt_r  <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign cmd_s = cmd_decode(rx_data_r);

    // Pulse stretcher: a matching byte starts a PULSE_CYC-long pulse only when idle;
    // commands arriving during a pulse are dropped, which keeps the buttons one-hot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_r  <= BTN_NONE;
            pcnt_r <= '0;
        end else begin
            if (btn_r != BTN_NONE) begin
                if (pcnt_r == '0) begin
                    btn_r <= BTN_NONE;
                end else begin
                    pcnt_r <= pcnt_r - P_ONE;
                end
            end else if (rx_done_r && (cmd_s != BTN_NONE)) begin
                btn_r  <= cmd_s;
                pcnt_r <= P_LOAD;
            end
        end
    end

    assign rx_data       = rx_data_r;
    assign rx_done       = rx_done_r;
    assign frame_err     = frame_err_r;
    assign o_btn_clear   = btn_r[0];
    assign o_btn_runstop = btn_r[1];
    assign o_btn_up      = btn_r[2];
    assign o_btn_down    = btn_r[3];

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: scaled line rate (10 clocks per tick, 160 per bit) and
// PULSE_CYC=1700, which separates frames with one idle bit (no overlap) from
// back-to-back frames (second command lands inside the first pulse).
module tb_uart_cmd_rx;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD      = 10_000;
    localparam int OVS       = 16;
    localparam int PULSE_CYC = 1700;
    localparam int DIV       = CLK_FREQ / (BAUD * OVS);
    localparam int BIT_CLKS  = DIV * OVS;
    localparam int SETTLE    = PULSE_CYC + 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       o_btn_clear;
    logic       o_btn_runstop;
    logic       o_btn_up;
    logic       o_btn_down;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_cmd_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .OVS      (OVS),
        .PULSE_CYC(PULSE_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .frame_err    (frame_err),
        .o_btn_clear  (o_btn_clear),
        .o_btn_runstop(o_btn_runstop),
        .o_btn_up     (o_btn_up),
        .o_btn_down   (o_btn_down)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Ticks are counted from reset release; a frame is tracked as a tick count since
    // start detection: mid-start at 8, data bit k at 8+16k, stop at 8+16*9.
    int         m_edges;
    logic       m_s1, m_s2;
    bit         m_busy, m_hold;
    int         m_ticks;
    logic [7:0] m_shift, m_data;
    bit         m_done, m_ferr;
    int         m_btn_idx, m_left;

    function automatic int cmd_index(input logic [7:0] b);
        logic [7:0] up;
        up = (b >= 8'h61 && b <= 8'h7a) ? (b - 8'h20) : b;
        case (up)
            8'h43:   return 0;
            8'h52:   return 1;
            8'h55:   return 2;
            8'h44:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_edges = 0; m_s1 = 1'b1; m_s2 = 1'b1;
        m_busy = 1'b0; m_hold = 1'b0; m_ticks = 0;
        m_shift = 8'h00; m_data = 8'h00; m_done = 1'b0; m_ferr = 1'b0;
        m_btn_idx = 0; m_left = 0;
    endtask

    task automatic model_step();
        bit tick, done_prev;
        logic rxs;
        logic [7:0] data_prev;
        int k, idx;
        tick      = (m_edges % DIV) == (DIV - 1);
        rxs       = m_s2;
        done_prev = m_done;
        data_prev = m_data;
        m_edges++;
        m_s2 = m_s1;
        m_s1 = rx;
        m_done = 1'b0;
        m_ferr = 1'b0;
        if (m_left > 0) begin
            m_left--;
        end else if (done_prev) begin
            idx = cmd_index(data_prev);
            if (idx >= 0) begin
                m_btn_idx = idx;
                m_left    = PULSE_CYC;
            end
        end
        if (tick) begin
            if (!m_busy) begin
                if (rxs) m_hold = 1'b0;
                else if (!m_hold) begin m_busy = 1'b1; m_ticks = 0; end
            end else begin
                m_ticks++;
                if (m_ticks == OVS / 2) begin
                    if (rxs) m_busy = 1'b0;
                end else if (m_ticks > OVS / 2 && ((m_ticks - OVS / 2) % OVS) == 0) begin
                    k = (m_ticks - OVS / 2) / OVS;
                    if (k <= 8) begin
                        m_shift[k-1] = rxs;
                    end else begin
                        m_busy = 1'b0;
                        if (rxs) begin m_data = m_shift; m_done = 1'b1; end
                        else begin m_ferr = 1'b1; m_hold = 1'b1; end
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare and monitors ----------------
    int         cyc = 0;
    int         n_done = 0, n_ferr = 0, onehot_viol = 0, last_done_cyc = 0;
    int         run_len [4];
    int         last_len[4];
    int         rises   [4];
    int         rise_cyc[4];
    logic [7:0] blog[$];

    initial begin
        logic [13:0] got, want;
        logic [3:0]  btns, prev_btns;
        logic [3:0]  exp_btn;
        for (int i = 0; i < 4; i++) begin
            run_len[i] = 0; last_len[i] = 0; rises[i] = 0; rise_cyc[i] = 0;
        end
        prev_btns = 4'b0000;
        forever begin
            @(negedge clk);
            cyc++;
            btns    = {o_btn_down, o_btn_up, o_btn_runstop, o_btn_clear};
            exp_btn = (m_left > 0) ? (4'b0001 << m_btn_idx) : 4'b0000;
            got     = {rx_data, rx_done, frame_err, btns};
            want    = {m_data, m_done, m_ferr, exp_btn};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL cycle_cmp @%0d: got data=%h done=%b ferr=%b btn=%b want data=%h done=%b ferr=%b btn=%b",
                         cyc, got[13:6], got[5], got[4], got[3:0], want[13:6], want[5], want[4], want[3:0]);
            end
            if (rx_done === 1'b1) begin n_done++; last_done_cyc = cyc; blog.push_back(rx_data); end
            if (frame_err === 1'b1) n_ferr++;
            if ($countones(btns) > 1) onehot_viol++;
            for (int i = 0; i < 4; i++) begin
                if (btns[i] === 1'b1) begin
                    if (prev_btns[i] !== 1'b1) begin rises[i]++; rise_cyc[i] = cyc; end
                    run_len[i]++;
                end else if (run_len[i] > 0) begin
                    last_len[i] = run_len[i];
                    run_len[i]  = 0;
                end
            end
            prev_btns = btns;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        rx = 1'b0; idle(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin rx = b[i]; idle(BIT_CLKS); end
        rx = stop_v; idle(BIT_CLKS);
        rx = 1'b1;
    endtask

    initial begin
        int d0, f0, nb, t0, lat;
        int r0[4];
        #1 rst = 1'b0;
        idle(4);
        chk("reset_outputs", {rx_data, rx_done, frame_err, o_btn_down, o_btn_up, o_btn_runstop, o_btn_clear}, 0);
        @(negedge clk); #2 rst = 1'b1;
        idle(2 * BIT_CLKS);

        // 1: 'R'
        d0 = n_done; t0 = cyc + 1;
        send_frame(8'h52, 1'b1);
        idle(SETTLE);
        lat = last_done_cyc - t0;
        chk("t1_rx_data", rx_data, 8'h52);
        chk("t1_model_data", m_data, 8'h52);
        chk("t1_done_count", n_done - d0, 1);
        chk("t1_latency_window", int'(lat >= 152 * DIV && lat <= 153 * DIV + 4), 1);
        chk("t1_runstop_len", last_len[1], PULSE_CYC);
        chk("t1_runstop_rises", rises[1], 1);
        chk("t1_other_rises", rises[0] + rises[2] + rises[3], 0);

        // 2: 'c','U','d' with one idle bit between frames
        nb = blog.size();
        send_frame(8'h63, 1'b1); idle(BIT_CLKS);
        send_frame(8'h55, 1'b1); idle(BIT_CLKS);
        send_frame(8'h64, 1'b1);
        idle(SETTLE);
        chk("t2_byte_count", blog.size() - nb, 3);
        if (blog.size() >= nb + 3) begin
            chk("t2_byte0", blog[nb], 8'h63);
            chk("t2_byte1", blog[nb+1], 8'h55);
            chk("t2_byte2", blog[nb+2], 8'h64);
        end
        chk("t2_rises_clear", rises[0], 1);
        chk("t2_rises_up", rises[2], 1);
        chk("t2_rises_down", rises[3], 1);
        chk("t2_len_clear", last_len[0], PULSE_CYC);
        chk("t2_len_up", last_len[2], PULSE_CYC);
        chk("t2_len_down", last_len[3], PULSE_CYC);
        chk("t2_order", int'(rise_cyc[0] < rise_cyc[2] && rise_cyc[2] < rise_cyc[3]), 1);
        chk("t2_onehot", onehot_viol, 0);

        // 3: 'U' then 'D' back-to-back; 'D' falls inside the up pulse and is dropped
        d0 = n_done;
        for (int i = 0; i < 4; i++) r0[i] = rises[i];
        send_frame(8'h55, 1'b1);
        send_frame(8'h44, 1'b1);
        idle(SETTLE);
        chk("t3_done_count", n_done - d0, 2);
        chk("t3_up_rises", rises[2] - r0[2], 1);
        chk("t3_up_len", last_len[2], PULSE_CYC);
        chk("t3_down_rises", rises[3] - r0[3], 0);
        chk("t3_rx_data", rx_data, 8'h44);

        // 4: 3-tick glitch, then a valid 'R'
        d0 = n_done; f0 = n_ferr;
        rx = 1'b0; idle(3 * DIV); rx = 1'b1;
        idle(3 * BIT_CLKS);
        chk("t4_glitch_no_done", n_done - d0, 0);
        chk("t4_glitch_no_ferr", n_ferr - f0, 0);
        for (int i = 0; i < 4; i++) r0[i] = rises[i];
        send_frame(8'h52, 1'b1);
        idle(SETTLE);
        chk("t4_rx_data", rx_data, 8'h52);
        chk("t4_runstop_rises", rises[1] - r0[1], 1);

        // 5: 0x55 with stop bit forced low
        d0 = n_done; f0 = n_ferr;
        for (int i = 0; i < 4; i++) r0[i] = rises[i];
        send_frame(8'h55, 1'b0);
        idle(2 * BIT_CLKS);
        chk("t5_ferr_count", n_ferr - f0, 1);
        chk("t5_no_done", n_done - d0, 0);
        chk("t5_rx_data_kept", rx_data, 8'h52);
        chk("t5_no_rise", (rises[0] + rises[1] + rises[2] + rises[3]) - (r0[0] + r0[1] + r0[2] + r0[3]), 0);

        // Break: line low for 15 bit times gives exactly one frame_err
        d0 = n_done; f0 = n_ferr;
        rx = 1'b0; idle(15 * BIT_CLKS); rx = 1'b1;
        idle(2 * BIT_CLKS);
        chk("brk_ferr_count", n_ferr - f0, 1);
        chk("brk_no_done", n_done - d0, 0);

        // 6: non-command 'x'
        d0 = n_done;
        for (int i = 0; i < 4; i++) r0[i] = rises[i];
        send_frame(8'h78, 1'b1);
        idle(SETTLE);
        chk("t6_rx_data", rx_data, 8'h78);
        chk("t6_done_count", n_done - d0, 1);
        chk("t6_no_rise", (rises[0] + rises[1] + rises[2] + rises[3]) - (r0[0] + r0[1] + r0[2] + r0[3]), 0);

        // Reset in the middle of an 'R' frame while a clear pulse is running
        send_frame(8'h43, 1'b1);
        idle(BIT_CLKS);
        d0 = n_done;
        fork
            send_frame(8'h52, 1'b1);
            begin
                idle(5 * BIT_CLKS);
                chk("rst_clear_active", o_btn_clear, 1);
                #2 rst = 1'b0;
                #1 chk("rst_mid_outputs", {rx_data, rx_done, frame_err, o_btn_down, o_btn_up, o_btn_runstop, o_btn_clear}, 0);
            end
        join
        idle(4);
        @(negedge clk); #2 rst = 1'b1;
        idle(2 * BIT_CLKS);
        chk("rst_no_done", n_done - d0, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("final_onehot", onehot_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
